wb_scoreboard_arbiter: RTL and testbench

WB_SCOREBOARD_ARBITER -- requirements
Module: wb_scoreboard_arbiter

---
 rtl/wb_scoreboard_arbiter.sv | 109 ++++++++++
 tb/tb_wb_scoreboard_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard_arbiter.sv
// wb_scoreboard_arbiter
//   Register scoreboard with a two-source writeback arbiter. The scoreboard
//   blocks issue on RAW/WAW hazards. The arbiter picks one writeback per
//   cycle. Loads win by default. An ALU writeback that has lost for
//   STARVE_LIMIT consecutive cycles is forced through on the next cycle.
//
//   Ports
//     clk, rst_n                    clock, async active-low reset
//     issue_*                       decode-side instruction operands
//     stall                         decode must hold (comb)
//     alu_wb_* / mem_wb_*           writeback requests; *_ready is the
//                                   grant (comb)
//     rf_we/rf_waddr/rf_wdata       registered register-file write port
//     busy                          registered per-register pending bits
module wb_scoreboard_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  input  logic [3:0]  issue_rs1,
  input  logic [3:0]  issue_rs2,
  input  logic        issue_uses_rs2,
  input  logic        issue_reg_write,
  output logic        stall,
  input  logic        alu_wb_valid,
  input  logic [3:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_wb_ready,
  input  logic        mem_wb_valid,
  input  logic [3:0]  mem_wb_rd,
  input  logic [31:0] mem_wb_data,
  output logic        mem_wb_ready,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] busy
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  logic          alu_gnt, mem_gnt, any_gnt, starved, issue_acc;
  logic          hz_rs1, hz_rs2, hz_rd;
  logic [SW-1:0] starve_cnt;
  logic [15:0]   busy_nxt;
  wb_req_t       sel;

  // Hazard checks. Register 0 never carries a pending write.
  assign hz_rs1 = (issue_rs1 != 4'd0) && busy[issue_rs1];
  assign hz_rs2 = issue_uses_rs2 && (issue_rs2 != 4'd0) && busy[issue_rs2];
  assign hz_rd  = issue_reg_write && (issue_rd != 4'd0) && busy[issue_rd];

  // Gating with rst_n holds stall and both grants low while reset is asserted.
  assign stall     = rst_n && issue_valid && (hz_rs1 || hz_rs2 || hz_rd);
  assign issue_acc = rst_n && issue_valid && !stall;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));
  assign alu_gnt = rst_n && alu_wb_valid && (!mem_wb_valid || starved);
  assign mem_gnt = rst_n && mem_wb_valid && !alu_gnt;
  assign any_gnt = alu_gnt || mem_gnt;

  assign alu_wb_ready = alu_gnt;
  assign mem_wb_ready = mem_gnt;

  always_comb begin
    sel = alu_gnt ? wb_req_t'{rd: alu_wb_rd, data: alu_wb_data}
                  : wb_req_t'{rd: mem_wb_rd, data: mem_wb_data};
  end

  // The set from a new issue is applied after the writeback clear, so a
  // new issue wins when both touch the same register on the same edge.
  always_comb begin
    busy_nxt = busy;
    if (rf_we)
      busy_nxt[rf_waddr] = 1'b0;
    if (issue_acc && issue_reg_write && (issue_rd != 4'd0))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= 4'd0;
      rf_wdata   <= 32'd0;
      busy       <= 16'h0000;
      starve_cnt <= '0;
    end else begin
      // A write to r0 still completes the handshake but never reaches the RF.
      rf_we <= any_gnt && (sel.rd != 4'd0);
      if (any_gnt) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
      if (!alu_wb_valid || alu_gnt)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + SW'(1);
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Directed bench for wb_scoreboard_arbiter. Inputs are driven 1ns after
// each rising edge. Outputs are sampled a few ns later, before the next edge.
module tb_wb_scoreboard_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_uses_rs2, issue_reg_write;
  logic [3:0]  issue_rd, issue_rs1, issue_rs2;
  logic        stall;
  logic        alu_wb_valid, alu_wb_ready;
  logic [3:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [3:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_scoreboard_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_uses_rs2(issue_uses_rs2),
    .issue_reg_write(issue_reg_write), .stall(stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd),
    .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd),
    .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic u2, input logic rw);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1;
    issue_rs2 = rs2; issue_uses_rs2 = u2; issue_reg_write = rw;
  endtask

  task automatic alu(input logic v, input logic [3:0] rd, input logic [31:0] d);
    alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
  endtask

  task automatic mem(input logic v, input logic [3:0] rd, input logic [31:0] d);
    mem_wb_valid = v; mem_wb_rd = rd; mem_wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    issue(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    alu(1'b1, 4'd1, 32'h1);
    mem(1'b1, 4'd2, 32'h2);
    #3;
    // Reset values, with every request asserted.
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_alu_rdy", alu_wb_ready, 0);
    chk("rst_mem_rdy", mem_wb_ready, 0);
    issue(1'b0, 0, 0, 0, 0, 0);
    alu(1'b0, 0, 0);
    mem(1'b0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Cycle 0: issue rd=5.
    step();
    issue(1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 1'b1);
    #2 chk("c0_stall", stall, 0);
    // Cycle 1: hazard checks against busy[5].
    step();
    chk("c1_busy", busy, 16'h0020);
    issue(1'b1, 4'd6, 4'd5, 4'd0, 1'b0, 1'b1);
    #1 chk("raw_rs1", stall, 1);
    issue(1'b1, 4'd0, 4'd1, 4'd5, 1'b0, 1'b0);
    #1 chk("rs2_unused", stall, 0);
    issue(1'b1, 4'd0, 4'd1, 4'd5, 1'b1, 1'b0);
    #1 chk("raw_rs2", stall, 1);
    issue(1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 1'b0);
    #1 chk("rd_nowrite", stall, 0);
    issue(1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 1'b1);
    #1 chk("waw_rd", stall, 1);
    issue(1'b0, 4'd5, 4'd5, 4'd5, 1'b1, 1'b1);
    #1 chk("no_valid_stall", stall, 0);
    // Cycle 3: ALU writeback of r5 while a dependent issue waits.
    step(); step();
    alu(1'b1, 4'd5, 32'hDEAD_BEEF);
    issue(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0);
    #2;
    chk("c3_alu_rdy", alu_wb_ready, 1);
    chk("c3_mem_rdy", mem_wb_ready, 0);
    chk("c3_stall", stall, 1);
    step();
    alu(1'b0, 0, 0);
    #2;
    chk("c4_rf_we", rf_we, 1);
    chk("c4_waddr", rf_waddr, 5);
    chk("c4_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("c4_busy", busy, 16'h0020);
    chk("c4_stall", stall, 1);
    step();
    #2;
    chk("c5_busy", busy, 0);
    chk("c5_stall", stall, 0);
    chk("c5_rf_we", rf_we, 0);
    chk("c5_wdata_hold", rf_wdata, 32'hDEAD_BEEF);
    step();
    issue(1'b0, 0, 0, 0, 0, 0);

    // Contention: mem wins three cycles, then ALU, repeating.
    alu(1'b1, 4'd3, 32'hA0A0_0003);
    mem(1'b1, 4'd4, 32'hB0B0_0004);
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("arb%0d_alu", k), alu_wb_ready, (k % 4 == 3) ? 1 : 0);
      chk($sformatf("arb%0d_mem", k), mem_wb_ready, (k % 4 == 3) ? 0 : 1);
      step();
      chk($sformatf("arb%0d_we", k), rf_we, 1);
      chk($sformatf("arb%0d_addr", k), rf_waddr, (k % 4 == 3) ? 3 : 4);
      chk($sformatf("arb%0d_data", k), rf_wdata,
          (k % 4 == 3) ? 32'hA0A0_0003 : 32'hB0B0_0004);
    end
    chk("unbusy_wb_busy", busy, 0);

    // Dropping the ALU request resets the starvation count.
    alu(1'b0, 4'd3, 32'hA0A0_0003);
    #2 chk("mem_only", mem_wb_ready, 1);
    step();
    alu(1'b1, 4'd3, 32'hA0A0_0003);
    step();
    #2 chk("st_a1_alu", alu_wb_ready, 0);
    step();
    alu(1'b0, 4'd3, 32'hA0A0_0003);
    step();
    alu(1'b1, 4'd3, 32'hA0A0_0003);
    step(); step();
    #2 chk("st_c2_alu", alu_wb_ready, 0);
    step();
    #2 chk("st_c3_alu", alu_wb_ready, 1);
    step();
    alu(1'b0, 0, 0);
    mem(1'b0, 0, 0);

    // Writeback to non-busy r7 and issue of rd=7 in the same cycle: set wins.
    alu(1'b1, 4'd7, 32'h77);
    step();
    alu(1'b0, 0, 0);
    issue(1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 1'b1);
    #2;
    chk("same_rf_we", rf_we, 1);
    chk("same_waddr", rf_waddr, 7);
    chk("same_stall", stall, 0);
    step();
    issue(1'b0, 0, 0, 0, 0, 0);
    chk("same_busy", busy, 16'h0080);
    // Issue of rd=0 leaves busy alone.
    issue(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    step();
    issue(1'b0, 0, 0, 0, 0, 0);
    chk("rd0_issue_busy", busy, 16'h0080);
    // A writeback to r0 is granted but produces no write.
    alu(1'b1, 4'd0, 32'h1234);
    #2 chk("rd0_wb_rdy", alu_wb_ready, 1);
    step();
    alu(1'b0, 0, 0);
    chk("rd0_wb_we", rf_we, 0);
    chk("rd0_wb_busy", busy, 16'h0080);

    // Reset during the grant cycle drops the writeback.
    issue(1'b1, 4'd9, 4'd0, 4'd0, 1'b0, 1'b1);
    step();
    issue(1'b0, 0, 0, 0, 0, 0);
    chk("r9_busy", busy, 16'h0280);
    alu(1'b1, 4'd9, 32'h99);
    #1 chk("r9_alu_rdy", alu_wb_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("rstg_alu_rdy", alu_wb_ready, 0);
    chk("rstg_busy", busy, 0);
    alu(1'b0, 0, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rstg_we0", rf_we, 0);
    step();
    chk("rstg_we1", rf_we, 0);
    chk("rstg_busy2", busy, 0);

    // Reset one cycle after the grant kills the pending write.
    issue(1'b1, 4'd9, 4'd0, 4'd0, 1'b0, 1'b1);
    step();
    issue(1'b0, 0, 0, 0, 0, 0);
    alu(1'b1, 4'd9, 32'h99);
    step();
    alu(1'b0, 0, 0);
    chk("r9b_we", rf_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rst1_we", rf_we, 0);
    chk("rst1_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst1_we_after", rf_we, 0);
    chk("rst1_busy_after", busy, 0);

    // Arbitration resumes right after reset.
    mem(1'b1, 4'd2, 32'h22);
    #2 chk("resume_mem_rdy", mem_wb_ready, 1);
    step();
    mem(1'b0, 0, 0);
    chk("resume_we", rf_we, 1);
    chk("resume_addr", rf_waddr, 2);
    chk("resume_data", rf_wdata, 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
